// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port (instruction / data) arbiter in front of a
// single-port synchronous memory. Data port has priority; the instruction
// port is guaranteed a grant after STARVE_LIMIT consecutive contested data
// grants. Every transaction takes exactly two cycles: ISSUE then RESP.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction in flight, sampling requests
// ISSUE_I | instruction read command on mem_* bus
// ISSUE_D | data read/write command on mem_* bus
// RESP_I  | i_ack pulse, read data returned, sampling next requests
// RESP_D  | d_ack pulse, read data returned, sampling next requests
module memory_arbiter #(
  parameter int BIT_WIDTH    = 32,
  parameter int DEPTH        = 128,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic                 i_ack,
  output logic                 i_err,
  output logic [BIT_WIDTH-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic                 d_ack,
  output logic                 d_err,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  input  logic [BIT_WIDTH-1:0] mem_rdata
);

  localparam int STREAK_W = (STARVE_LIMIT < 3) ? 2 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    ISSUE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [STREAK_W-1:0]   r_streak;
  logic [BIT_WIDTH-1:0]  r_addr;
  logic                  r_we;
  logic [BIT_WIDTH-1:0]  r_wdata;
  logic                  w_in_range;
  logic                  w_take_i;
  logic                  w_take_d;

  // Extra top bit keeps the compare unsigned and full-width even when DEPTH
  // does not fit in BIT_WIDTH bits.
  assign w_in_range = ({1'b0, r_addr} < (BIT_WIDTH + 1)'(DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state, arbitration and output decode
  always_comb begin
    w_next    = r_state;
    w_take_i  = 1'b0;
    w_take_d  = 1'b0;
    i_ack     = 1'b0;
    i_err     = 1'b0;
    i_rdata   = '0;
    d_ack     = 1'b0;
    d_err     = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ISSUE_I: begin
        mem_en   = w_in_range;
        mem_addr = r_addr;
        w_next   = RESP_I;
      end
      ISSUE_D: begin
        mem_en    = w_in_range;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        w_next    = RESP_D;
      end
      default: begin
        if (r_state == RESP_I) begin
          i_ack   = 1'b1;
          i_err   = ~w_in_range;
          i_rdata = w_in_range ? mem_rdata : '0;
        end
        if (r_state == RESP_D) begin
          d_ack   = 1'b1;
          d_err   = ~w_in_range;
          d_rdata = (w_in_range && !r_we) ? mem_rdata : '0;
        end
        w_take_d = d_req && !(i_req && (r_streak == STREAK_W'(STARVE_LIMIT)));
        w_take_i = i_req && !w_take_d;
        if (w_take_d)      w_next = ISSUE_D;
        else if (w_take_i) w_next = ISSUE_I;
        else               w_next = IDLE;
      end
    endcase
  end

  // Latch the winner's command and track the contested data-grant streak
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
    end else if (w_take_d) begin
      r_streak <= i_req ? r_streak + 1'b1 : '0;
      r_addr   <= d_addr;
      r_we     <= d_we;
      r_wdata  <= d_wdata;
    end else if (w_take_i) begin
      r_streak <= '0;
      r_addr   <= i_addr;
      r_we     <= 1'b0;
      r_wdata  <= '0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small behavioural memory.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem [0:127];

  memory_arbiter #(.BIT_WIDTH(32), .DEPTH(128), .STARVE_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data valid the cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[6:0]] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr[6:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_iack"}, i_ack, 0);
    chk({tag, "_dack"}, d_ack, 0);
    chk({tag, "_ierr"}, i_err, 0);
    chk({tag, "_derr"}, d_err, 0);
    chk({tag, "_irdata"}, i_rdata, 0);
    chk({tag, "_drdata"}, d_rdata, 0);
    chk({tag, "_memen"}, mem_en, 0);
    chk({tag, "_memwe"}, mem_we, 0);
    chk({tag, "_memaddr"}, mem_addr, 0);
    chk({tag, "_memwdata"}, mem_wdata, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) tb_mem[i] = 32'h1000_0000 + i;
    mem_rdata = 32'h0;
    reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    tick(); tick();
    chk_quiet("reset");
    reset = 1'b0;
    tick();
    chk_quiet("idle");

    // Single instruction read
    i_req = 1; i_addr = 5;
    tick();
    chk("i5_issue_en", mem_en, 1);
    chk("i5_issue_we", mem_we, 0);
    chk("i5_issue_addr", mem_addr, 5);
    chk("i5_issue_iack", i_ack, 0);
    tick();
    chk("i5_ack", i_ack, 1);
    chk("i5_rdata", i_rdata, 32'h1000_0005);
    chk("i5_err", i_err, 0);
    chk("i5_dack", d_ack, 0);
    chk("i5_resp_memen", mem_en, 0);
    i_req = 0;
    tick();
    chk_quiet("i5_after");

    // Simultaneous request: data write wins, then instruction
    i_req = 1; i_addr = 9;
    d_req = 1; d_we = 1; d_addr = 7; d_wdata = 32'h0000_DEAD;
    tick();
    chk("wr_issue_en", mem_en, 1);
    chk("wr_issue_we", mem_we, 1);
    chk("wr_issue_addr", mem_addr, 7);
    chk("wr_issue_wdata", mem_wdata, 32'h0000_DEAD);
    tick();
    chk("wr_dack", d_ack, 1);
    chk("wr_iack", i_ack, 0);
    chk("wr_drdata", d_rdata, 0);
    chk("wr_derr", d_err, 0);
    d_req = 0; d_we = 0;
    tick();
    chk("i9_issue_addr", mem_addr, 9);
    chk("i9_issue_we", mem_we, 0);
    chk("i9_issue_wdata", mem_wdata, 0);
    tick();
    chk("i9_ack", i_ack, 1);
    chk("i9_rdata", i_rdata, 32'h1000_0009);
    i_req = 0;
    tick();

    // Read back the written word through the data port
    d_req = 1; d_we = 0; d_addr = 7;
    tick();
    chk("rd7_issue_en", mem_en, 1);
    tick();
    chk("rd7_ack", d_ack, 1);
    chk("rd7_rdata", d_rdata, 32'h0000_DEAD);
    d_req = 0;
    tick();

    // Both held continuously: D,D,I,D,D,I with acks two cycles apart
    i_req = 1; i_addr = 3; d_req = 1; d_we = 0; d_addr = 4;
    for (int k = 0; k < 6; k++) begin
      automatic logic exp_d = (k % 3 != 2);
      tick();
      chk($sformatf("stv%0d_issue_addr", k), mem_addr, exp_d ? 32'd4 : 32'd3);
      chk($sformatf("stv%0d_issue_ack", k), i_ack | d_ack, 0);
      tick();
      chk($sformatf("stv%0d_dack", k), d_ack, exp_d);
      chk($sformatf("stv%0d_iack", k), i_ack, !exp_d);
      if (exp_d) chk($sformatf("stv%0d_drdata", k), d_rdata, 32'h1000_0004);
      else       chk($sformatf("stv%0d_irdata", k), i_rdata, 32'h1000_0003);
    end
    i_req = 0; d_req = 0;
    tick();
    chk_quiet("stv_after");

    // Out-of-range data read at DEPTH
    d_req = 1; d_we = 0; d_addr = 128;
    tick();
    chk("oor128_memen", mem_en, 0);
    tick();
    chk("oor128_ack", d_ack, 1);
    chk("oor128_err", d_err, 1);
    chk("oor128_rdata", d_rdata, 0);
    chk("oor128_memen2", mem_en, 0);
    d_req = 0;
    tick();

    // Last valid address
    i_req = 1; i_addr = 127;
    tick();
    chk("in127_memen", mem_en, 1);
    tick();
    chk("in127_ack", i_ack, 1);
    chk("in127_err", i_err, 0);
    chk("in127_rdata", i_rdata, 32'h1000_007F);
    i_req = 0;
    tick();

    // High address bits must not be truncated into range
    i_req = 1; i_addr = 32'h8000_0005;
    tick();
    chk("hi_memen", mem_en, 0);
    tick();
    chk("hi_ack", i_ack, 1);
    chk("hi_err", i_err, 1);
    chk("hi_rdata", i_rdata, 0);
    i_req = 0;
    tick();

    // Reset during ISSUE_D aborts; request reissued after release
    d_req = 1; d_we = 0; d_addr = 2;
    tick();
    chk("abort_issue_en", mem_en, 1);
    reset = 1;
    tick();
    chk_quiet("abort_reset");
    reset = 0;
    tick();
    chk("abort_reissue_en", mem_en, 1);
    chk("abort_reissue_addr", mem_addr, 2);
    chk("abort_reissue_dack", d_ack, 0);
    tick();
    chk("abort_ack", d_ack, 1);
    chk("abort_rdata", d_rdata, 32'h1000_0002);
    d_req = 0;
    tick();
    chk_quiet("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 32, width of address and data words.
REQ-002 The block SHALL have parameter DEPTH, default 128, number of valid word addresses (0..DEPTH-1).
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 2, max consecutive contested data grants before instruction port wins.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port i_req  input  1  instruction-fetch read request, held until i_ack.
REQ-007 The block SHALL have port i_addr  input  BIT_WIDTH  instruction word address, stable while i_req high.
REQ-008 The block SHALL have ports i_ack, i_err (output, 1) and i_rdata (output, BIT_WIDTH)  completion pulse, range error, read data.
REQ-009 The block SHALL have ports d_req, d_we (input, 1), d_addr, d_wdata (input, BIT_WIDTH)  data request, write enable, word address, write data, all stable until d_ack.
REQ-010 The block SHALL have ports d_ack, d_err (output, 1) and d_rdata (output, BIT_WIDTH)  completion pulse, range error, read data.
REQ-011 The block SHALL have ports mem_en, mem_we (output, 1), mem_addr, mem_wdata (output, BIT_WIDTH)  single-port memory command.
REQ-012 The block SHALL have port mem_rdata  input  BIT_WIDTH  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE_I, ISSUE_D, RESP_I, RESP_D.
REQ-014 In IDLE and in RESP_I/RESP_D, requests sampled at the clock edge SHALL select next state ISSUE_I or ISSUE_D; no request -> IDLE.
REQ-015 Arbitration SHALL be data-priority: d_req alone -> ISSUE_D; i_req alone -> ISSUE_I; both -> ISSUE_D unless streak == STARVE_LIMIT, then ISSUE_I.
REQ-016 A 2-bit-or-wider streak counter SHALL increment on each ISSUE_D grant taken while i_req=1, clear on any ISSUE_I grant, and clear on an ISSUE_D grant with i_req=0.
REQ-017 On grant, address/we/wdata of the winner SHALL be latched into registers; mem_* outputs SHALL be driven from these registers during ISSUE_x only.
REQ-018 ISSUE_x SHALL last exactly one cycle, then go to RESP_x unconditionally.
REQ-019 In ISSUE_x, mem_en=1 if latched address < DEPTH, else mem_en=0; mem_we=latched we (0 for instruction); mem_en=mem_we=0 in all other states.
REQ-020 In RESP_x, x_ack SHALL be 1 for exactly that cycle; the other port's ack SHALL be 0.
REQ-021 In RESP_x, x_rdata SHALL equal mem_rdata for an in-range read, else 0 (writes and out-of-range); x_rdata=0 outside RESP_x.
REQ-022 In RESP_x, x_err SHALL be 1 iff latched address >= DEPTH; out-of-range accesses never assert mem_en.
REQ-023 Latency SHALL be fixed: request sampled at edge N -> ISSUE at cycle N+1 -> ack at cycle N+2; max throughput one transaction per two cycles.
REQ-024 A req still high at the edge ending its ack cycle SHALL be treated as a new request.
REQ-025 Address compare SHALL be unsigned on the full BIT_WIDTH; no truncation or wrap-around of addresses.

Reset
REQ-026 With reset=1 at a clock edge, state SHALL go to IDLE, streak to 0, latched registers to 0; all outputs SHALL be 0 in the following cycle.
REQ-027 Reset during ISSUE_x or RESP_x SHALL abort the transaction: no ack issued; requester re-requests after reset.
REQ-028 Requests SHALL be ignored in any cycle where reset=1.

Verification
REQ-029 After reset, i_req=1, i_addr=5 -> cycle 1 mem_en=1, mem_we=0, mem_addr=5; cycle 2 i_ack=1, i_rdata=mem_rdata, i_err=0.
REQ-030 i_req and d_req (d_we=1, d_addr=7, d_wdata=0xDEAD) raised together -> cycle 1 mem_we=1, mem_addr=7, mem_wdata=0xDEAD; cycle 2 d_ack=1; cycle 3 mem_addr=i_addr; cycle 4 i_ack=1.
REQ-031 i_req and d_req held continuously, STARVE_LIMIT=2 -> grant order D,D,I,D,D,I, each ack two cycles apart.
REQ-032 d_req=1, d_we=0, d_addr=128 -> mem_en stays 0; cycle 2 d_ack=1, d_err=1, d_rdata=0.
REQ-033 reset=1 asserted during ISSUE_D -> no d_ack, all outputs 0 next cycle, state IDLE; after release d_req reissues and acks at cycle +2.
